sata_link_tx_framer: RTL and testbench
======================================

# sata_link_tx_framer

Link-layer transmit framer for SerialATA: the read side of the TX link FIFO. On a start command it builds one FIS frame on the 32-bit link stream. The frame is SOF, the payload dwords drained from the show-ahead FIFO, the CRC dword, then EOF. HOLD is inserted when the FIFO starves and HOLDA is sent when the far end requests a hold. The block sits between the TX link FIFO and the scrambler/8b10b path, and is commanded by the link-layer protocol FSM.

## Interface
Parameters:
- `CRC_INIT`, `32'h52325032`: CRC-32 seed applied at every SOF.

Ports:
- `reset_n`  in  1: synchronous reset, active low.
- `clk`  in  1: single clock; all logic runs on its rising edge.
- `start`  in  1: one-cycle frame request from the link FSM; sampled only in IDLE.
- `hold_rx`  in  1: far end is sending HOLD; level signal.
- `busy`  out  1: high from the cycle after an accepted `start` through the EOF cycle.
- `done`  out  1: one-cycle pulse, coincident with EOF on `tx_data`.
- `fifo_data`  in  32: FIFO head dword (show-ahead).
- `fifo_eop`  in  1: FIFO head dword is the last dword of the frame.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rdreq`  out  1: pop the FIFO head; combinational.
- `tx_data`  out  32: link dword, registered.
- `tx_datak`  out  1: 1 when `tx_data` is a primitive (byte 0 is K28.3); registered.
- `tx_ready`  in  1: downstream accepts `tx_data`; when low, the whole block stalls.

## Operation
- Primitive values, byte 0 first on the line:
  - SYNC `32'hB5B5957C`
  - SOF `32'h3737B57C`
  - EOF `32'hD5D5B57C`
  - HOLD `32'hD5D5AA7C`
  - HOLDA `32'h9595AA7C`
- FSM states and transitions. All transitions happen only on `tx_ready`=1 edges.
  - IDLE: emit SYNC. `start`=1 -> SOF.
  - SOF: emit SOF, reload CRC with `CRC_INIT` -> DATA.
  - DATA: evaluated in priority order, first match wins:
    - `hold_rx`=1: emit HOLDA, no pop, stay.
    - `fifo_empty`=1: emit HOLD, no pop, stay.
    - otherwise: pop, emit `fifo_data` with `tx_datak`=0, fold the dword into the CRC. If `fifo_eop`=1 -> CRC.
  - CRC: emit the final CRC dword with `tx_datak`=0 -> EOF.
  - EOF: emit EOF, pulse `done` -> IDLE.
- Output assignment is per-cycle from the state, so HOLD and HOLDA stop the cycle after their condition clears. The DATA priority list above also covers `hold_rx` and `fifo_empty` both high: HOLDA is emitted.
- `fifo_rdreq` = DATA & `tx_ready` & !`hold_rx` & !`fifo_empty`. It is never asserted outside DATA.
- CRC: polynomial `32'h04C11DB7`, non-reflected, MSB-first over each dword, no final XOR. It covers payload dwords only; the CRC dword itself is not folded in.
- `start` outside IDLE is ignored. A `fifo_eop` on a dword not in DATA has no effect.
- Reset (`reset_n`=0 at an edge) forces the following:
  - state IDLE, `tx_data`=SYNC, `tx_datak`=1, `busy`=0, `done`=0, CRC=`CRC_INIT`;
  - `fifo_rdreq`=0 while reset is low.
  - Any FIFO residue from an aborted frame is the owner's to clear.

## Timing
- `start` in IDLE at edge N with `tx_ready`=1 -> SOF on `tx_data` after edge N+1. The first payload dword appears after edge N+2 if the FIFO is non-empty.
- Pop and emit happen in the same cycle: `tx_data` after edge k equals the `fifo_data` sampled at edge k.
- Minimum frame of 1 payload dword occupies 4 consecutive output cycles: SOF, D0, CRC, EOF.
- `tx_ready`=0 stalls everything: outputs hold, state holds, CRC holds, `fifo_rdreq`=0, `done` stays low.
- Sustained throughput is 1 dword per cycle with the FIFO non-empty and `hold_rx`=0.

## Configuration
- `SATA_LINK_TX_CRC_INJECT_EN` defined:
  - adds input port `crc_corrupt` (1 bit), sampled in the CRC state;
  - `crc_corrupt`=1 inverts bit 0 of the emitted CRC dword;
  - the internal CRC register is unaffected.
- Undefined: the port is absent and the CRC is always correct.

## Structure
- Shared package `sata_link_pkg` holds:
  - the primitive constants (SYNC, SOF, EOF, HOLD, HOLDA);
  - the CRC polynomial and default seed;
  - the framer state enum.
- One sub-module, `sata_link_crc32`: a combinational next-CRC function of current CRC and a 32-bit dword. The RX checker reuses it.

## Test plan
- Single frame, dwords `32'h00000001`, `32'h00000002` (eop): output is SOF, 1, 2, CRC, EOF. CRC must match the golden model. `done` is coincident with EOF. Two pops. SYNC before and after.
- FIFO starvation: push D0, then leave the FIFO empty for 3 cycles, then push D1 with eop. Output is SOF, D0, HOLD×3, D1, CRC, EOF. CRC equals the CRC of the unstalled frame.
- `hold_rx` high 2 cycles mid-frame with the FIFO non-empty: HOLDA×2, no `fifo_rdreq` during them, then data resumes in order. Also raise `hold_rx` while the FIFO is empty: HOLDA is emitted.
- `tx_ready` low 4 cycles during the DATA state: `tx_data` frozen, `fifo_rdreq`=0. Resuming `tx_ready` continues the frame with no dword lost or duplicated.
- Reset asserted during DATA: the next cycle shows SYNC with `tx_datak`=1, `busy`=0. A later `start` produces SOF with the CRC reseeded.
- With `SATA_LINK_TX_CRC_INJECT_EN` and `crc_corrupt`=1: the CRC dword equals the golden CRC with bit 0 inverted. The next frame with `crc_corrupt`=0 has the golden CRC.

Source files
------------

// File: rtl/sata_link_pkg.sv
// Shared SATA link-layer definitions: primitive dwords, CRC parameters and framer states.
package sata_link_pkg;

  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_SEED = 32'h52325032;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CRC,
    ST_EOF
  } framer_state_t;

endpackage

// File: rtl/sata_link_crc32.sv
// Combinational next-CRC: folds one dword MSB-first into the running CRC-32 (no reflection, no final XOR).
module sata_link_crc32
  import sata_link_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (crc_out[31] ^ data[i]) begin
        crc_out = {crc_out[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sata_link_tx_framer.sv
// TX link framer: SOF, payload (HOLD on starve, HOLDA on far-end hold), CRC, EOF; registered output, tx_ready=0 freezes all.
// Optional SATA_LINK_TX_CRC_INJECT_EN adds crc_corrupt to flip bit 0 of the emitted CRC dword.
module sata_link_tx_framer
  import sata_link_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = CRC_SEED
) (
  input  logic        reset_n,
  input  logic        clk,
  input  logic        start,
  input  logic        hold_rx,
  output logic        busy,
  output logic        done,
  input  logic [31:0] fifo_data,
  input  logic        fifo_eop,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [31:0] tx_data,
  output logic        tx_datak,
  input  logic        tx_ready
`ifdef SATA_LINK_TX_CRC_INJECT_EN
  ,
  input  logic        crc_corrupt
`endif
);

  framer_state_t state, state_nxt;
  logic [31:0]   crc, crc_nxt, crc_fold, data_nxt;
  logic          datak_nxt, busy_nxt, done_nxt, pop, crc_flip;

  sata_link_crc32 u_crc (
    .crc_in (crc),
    .data   (fifo_data),
    .crc_out(crc_fold)
  );

`ifdef SATA_LINK_TX_CRC_INJECT_EN
  assign crc_flip = crc_corrupt;
`else
  assign crc_flip = 1'b0;
`endif

  // Reset gating keeps the FIFO untouched while the block is being cleared.
  assign pop        = reset_n && tx_ready && (state == ST_DATA) && !hold_rx && !fifo_empty;
  assign fifo_rdreq = pop;

  always_comb begin
    state_nxt = state;
    data_nxt  = tx_data;
    datak_nxt = tx_datak;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    crc_nxt   = crc;
    if (tx_ready) begin
      busy_nxt = 1'b1;
      case (state)
        ST_IDLE: begin
          data_nxt  = PRIM_SYNC;
          datak_nxt = 1'b1;
          busy_nxt  = start;
          if (start) state_nxt = ST_SOF;
        end
        ST_SOF: begin
          data_nxt  = PRIM_SOF;
          datak_nxt = 1'b1;
          crc_nxt   = CRC_INIT;
          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (hold_rx) begin
            data_nxt  = PRIM_HOLDA;
            datak_nxt = 1'b1;
          end else if (fifo_empty) begin
            data_nxt  = PRIM_HOLD;
            datak_nxt = 1'b1;
          end else begin
            data_nxt  = fifo_data;
            datak_nxt = 1'b0;
            crc_nxt   = crc_fold;
            if (fifo_eop) state_nxt = ST_CRC;
          end
        end
        ST_CRC: begin
          data_nxt  = crc ^ {31'b0, crc_flip};
          datak_nxt = 1'b0;
          state_nxt = ST_EOF;
        end
        ST_EOF: begin
          data_nxt  = PRIM_EOF;
          datak_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          data_nxt  = PRIM_SYNC;
          datak_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tx_data  <= PRIM_SYNC;
      tx_datak <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc      <= CRC_INIT;
    end else begin
      state    <= state_nxt;
      tx_data  <= data_nxt;
      tx_datak <= datak_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      crc      <= crc_nxt;
    end
  end

endmodule

// File: tb/tb_sata_link_tx_framer.sv
// Directed and randomized bench for sata_link_tx_framer with a FIFO model and a polynomial-division CRC reference.
module tb_sata_link_tx_framer;

  localparam logic [31:0] SYNC  = 32'hB5B5957C;
  localparam logic [31:0] SOF   = 32'h3737B57C;
  localparam logic [31:0] EOF   = 32'hD5D5B57C;
  localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] HOLDA = 32'h9595AA7C;
  localparam logic [31:0] SEED  = 32'h52325032;

  logic        clk = 1'b0;
  logic        reset_n, start, hold_rx, busy, done;
  logic [31:0] fifo_data, tx_data;
  logic        fifo_eop, fifo_empty, fifo_rdreq, tx_datak, tx_ready;
`ifdef SATA_LINK_TX_CRC_INJECT_EN
  logic        crc_corrupt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          pops, viol;
  logic        starve, last_rd, last_ready;
  logic [32:0] fq[$];

  sata_link_tx_framer dut (
    .reset_n(reset_n), .clk(clk), .start(start), .hold_rx(hold_rx),
    .busy(busy), .done(done), .fifo_data(fifo_data), .fifo_eop(fifo_eop),
    .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq), .tx_data(tx_data),
    .tx_datak(tx_datak), .tx_ready(tx_ready)
`ifdef SATA_LINK_TX_CRC_INJECT_EN
    , .crc_corrupt(crc_corrupt)
`endif
  );

  always #5 clk = ~clk;

  // CRC as the remainder of ((crc ^ dword) * x^32) modulo the generator polynomial.
  function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] v;
    v = {c ^ d, 32'h0};
    for (int i = 63; i >= 32; i--)
      if (v[i]) v = v ^ (64'h1_04C1_1DB7 << (i - 32));
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic k);
    chk({tag, "_data"}, {32'h0, tx_data}, {32'h0, d});
    chk({tag, "_datak"}, {63'h0, tx_datak}, {63'h0, k});
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0) || starve;
    fifo_data  = (fq.size() != 0) ? fq[0][31:0] : 32'hDEADBEEF;
    fifo_eop   = (fq.size() != 0) ? fq[0][32] : 1'b0;
  endtask

  task automatic step();
    logic rd, rdy, hr, emp;
    logic [32:0] prev;
    drive_fifo();
    #1;
    rd = fifo_rdreq; rdy = tx_ready; hr = hold_rx; emp = fifo_empty;
    prev = {tx_datak, tx_data};
    @(posedge clk);
    #1;
    last_rd = rd;
    last_ready = rdy;
    if (rd && (hr || !rdy || emp)) viol++;
    if (reset_n && !rdy && (({tx_datak, tx_data} !== prev) || done)) viol++;
    if (rd && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  task automatic begin_frame(input string tag);
    start = 1'b1;
    step();
    chk({tag, "_busy_rise"}, {63'h0, busy}, 64'h1);
    start = 1'b0;
    step();
    chk_out({tag, "_sof"}, SOF, 1'b1);
  endtask

  initial begin
    logic [31:0] d0, d1, d2, crc_exp;
    logic [32:0] rec[$];
    logic [32:0] exp_q[$];
    logic        got_eof;
    int          n, dn;

    reset_n = 1'b0; start = 1'b0; hold_rx = 1'b0; tx_ready = 1'b1; starve = 1'b0;
    pops = 0; viol = 0; last_rd = 1'b0; last_ready = 1'b0;
`ifdef SATA_LINK_TX_CRC_INJECT_EN
    crc_corrupt = 1'b0;
`endif
    fq.push_back({1'b1, 32'h12345678});
    repeat (3) step();
    chk("rst_rdreq", {63'h0, fifo_rdreq}, 64'h0);
    chk_out("rst", SYNC, 1'b1);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    fq.delete();
    reset_n = 1'b1;
    step();
    chk_out("idle", SYNC, 1'b1);

    // basic two-dword frame
    fq.push_back({1'b0, 32'h1});
    fq.push_back({1'b1, 32'h2});
    pops = 0;
    begin_frame("t1");
    step(); chk_out("t1_d0", 32'h1, 1'b0); chk("t1_pop0", {63'h0, last_rd}, 64'h1);
    step(); chk_out("t1_d1", 32'h2, 1'b0);
    step(); chk_out("t1_crc", crc_fold(crc_fold(SEED, 32'h1), 32'h2), 1'b0);
    chk("t1_done_early", {63'h0, done}, 64'h0);
    step(); chk_out("t1_eof", EOF, 1'b1);
    chk("t1_done", {63'h0, done}, 64'h1);
    chk("t1_busy_eof", {63'h0, busy}, 64'h1);
    step(); chk_out("t1_after", SYNC, 1'b1);
    chk("t1_busy_fall", {63'h0, busy}, 64'h0);
    chk("t1_done_fall", {63'h0, done}, 64'h0);
    chk("t1_pops", pops, 2);

    // FIFO starvation for three cycles
    d0 = $urandom; d1 = $urandom;
    fq.push_back({1'b0, d0});
    begin_frame("t2");
    step(); chk_out("t2_d0", d0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("t2_hold", HOLD, 1'b1);
      chk("t2_hold_nopop", {63'h0, last_rd}, 64'h0);
    end
    fq.push_back({1'b1, d1});
    step(); chk_out("t2_d1", d1, 1'b0);
    step(); chk_out("t2_crc", crc_fold(crc_fold(SEED, d0), d1), 1'b0);
    step(); chk_out("t2_eof", EOF, 1'b1);
    step();

    // far-end hold with data waiting, then with FIFO empty
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    fq.push_back({1'b0, d0}); fq.push_back({1'b0, d1}); fq.push_back({1'b1, d2});
    begin_frame("t3");
    step(); chk_out("t3_d0", d0, 1'b0);
    hold_rx = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); chk_out("t3_holda", HOLDA, 1'b1);
      chk("t3_holda_nopop", {63'h0, last_rd}, 64'h0);
    end
    hold_rx = 1'b0;
    step(); chk_out("t3_d1", d1, 1'b0);
    step(); chk_out("t3_d2", d2, 1'b0);
    step(); chk_out("t3_crc", crc_fold(crc_fold(crc_fold(SEED, d0), d1), d2), 1'b0);
    step(); chk_out("t3_eof", EOF, 1'b1);
    step();
    d0 = $urandom;
    fq.push_back({1'b1, d0});
    begin_frame("t3b");
    hold_rx = 1'b1; starve = 1'b1;
    step(); chk_out("t3b_holda_empty", HOLDA, 1'b1);
    hold_rx = 1'b0;
    step(); chk_out("t3b_hold", HOLD, 1'b1);
    starve = 1'b0;
    step(); chk_out("t3b_d0", d0, 1'b0);
    step(); chk_out("t3b_crc", crc_fold(SEED, d0), 1'b0);
    step(); chk_out("t3b_eof", EOF, 1'b1);
    step();

    // downstream stall for four cycles in DATA
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    fq.push_back({1'b0, d0}); fq.push_back({1'b0, d1}); fq.push_back({1'b1, d2});
    pops = 0;
    begin_frame("t4");
    step(); chk_out("t4_d0", d0, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("t4_frozen", d0, 1'b0);
      chk("t4_stall_nopop", {63'h0, last_rd}, 64'h0);
    end
    tx_ready = 1'b1;
    step(); chk_out("t4_d1", d1, 1'b0);
    step(); chk_out("t4_d2", d2, 1'b0);
    step(); chk_out("t4_crc", crc_fold(crc_fold(crc_fold(SEED, d0), d1), d2), 1'b0);
    step(); chk_out("t4_eof", EOF, 1'b1);
    chk("t4_pops", pops, 3);
    step();

    // reset in the middle of DATA, then a clean frame
    d0 = $urandom;
    fq.push_back({1'b0, d0}); fq.push_back({1'b0, ~d0}); fq.push_back({1'b1, d0 ^ 32'h5A5A});
    begin_frame("t5");
    step(); chk_out("t5_d0", d0, 1'b0);
    reset_n = 1'b0;
    drive_fifo();
    #1;
    chk("t5_rst_rdreq", {63'h0, fifo_rdreq}, 64'h0);
    step(); chk_out("t5_rst", SYNC, 1'b1);
    chk("t5_rst_busy", {63'h0, busy}, 64'h0);
    chk("t5_rst_done", {63'h0, done}, 64'h0);
    reset_n = 1'b1;
    fq.delete();
    d1 = $urandom;
    fq.push_back({1'b1, d1});
    begin_frame("t5b");
    step(); chk_out("t5b_d", d1, 1'b0);
    step(); chk_out("t5b_crc", crc_fold(SEED, d1), 1'b0);
    step(); chk_out("t5b_eof", EOF, 1'b1);
    step();

`ifdef SATA_LINK_TX_CRC_INJECT_EN
    for (int f = 0; f < 2; f++) begin
      d0 = $urandom;
      fq.push_back({1'b1, d0});
      begin_frame("t6");
      step(); chk_out("t6_d", d0, 1'b0);
      crc_corrupt = (f == 0);
      step(); chk_out("t6_crc", crc_fold(SEED, d0) ^ ((f == 0) ? 32'h1 : 32'h0), 1'b0);
      crc_corrupt = 1'b0;
      step(); chk_out("t6_eof", EOF, 1'b1);
      step();
    end
`endif

    chk("directed_rules", viol, 0);

    // randomized frames with random holds, starvation, stalls and stray starts
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 8);
      fq.delete(); exp_q.delete(); rec.delete();
      crc_exp = SEED;
      exp_q.push_back({1'b1, SOF});
      for (int i = 0; i < n; i++) begin
        d0 = $urandom;
        fq.push_back({(i == n - 1), d0});
        exp_q.push_back({1'b0, d0});
        crc_exp = crc_fold(crc_exp, d0);
      end
      exp_q.push_back({1'b0, crc_exp});
      exp_q.push_back({1'b1, EOF});
      pops = 0; viol = 0; dn = 0; got_eof = 1'b0;
      hold_rx = 1'b0; starve = 1'b0; tx_ready = 1'b1; start = 1'b1;
      step();
      for (int c = 0; c < 400 && !got_eof; c++) begin
        hold_rx  = ($urandom_range(0, 3) == 0);
        starve   = ($urandom_range(0, 3) == 0);
        tx_ready = ($urandom_range(0, 3) != 0);
        start    = ($urandom_range(0, 7) == 0);
        step();
        if (!busy) viol++;
        if (done) dn++;
        if (done && !(tx_datak && tx_data == EOF)) viol++;
        if (last_ready && !(tx_datak && (tx_data == HOLD || tx_data == HOLDA)))
          rec.push_back({tx_datak, tx_data});
        if (last_ready && tx_datak && tx_data == EOF) got_eof = 1'b1;
      end
      start = 1'b0; hold_rx = 1'b0; starve = 1'b0; tx_ready = 1'b1;
      chk("rnd_eof_seen", {63'h0, got_eof}, 64'h1);
      chk("rnd_len", rec.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rec.size(); i++)
        chk("rnd_word", {31'h0, rec[i]}, {31'h0, exp_q[i]});
      chk("rnd_pops", pops, n);
      chk("rnd_done_count", dn, 1);
      chk("rnd_rules", viol, 0);
      step();
      chk_out("rnd_idle", SYNC, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
